// File: rtl/sys_defs.sv
// Shared pipeline definitions: issue packet layout, execution channel and operand selects.
package sys_defs;

    typedef enum logic [1:0] {
        ALU  = 2'd0,
        BR   = 2'd1,
        MULT = 2'd2
    } channel_t;

    typedef enum logic [1:0] {
        OPA_IS_RS1  = 2'd0,
        OPA_IS_NPC  = 2'd1,
        OPA_IS_PC   = 2'd2,
        OPA_IS_ZERO = 2'd3
    } alu_opa_select;

    typedef enum logic [1:0] {
        OPB_IS_RS2   = 2'd0,
        OPB_IS_I_IMM = 2'd1,
        OPB_IS_S_IMM = 2'd2,
        OPB_IS_B_IMM = 2'd3
    } alu_opb_select;

    typedef struct packed {
        logic [31:0]   PC;
        logic [31:0]   inst;
        channel_t      channel;
        alu_opa_select opa_select;
        alu_opb_select opb_select;
        logic [4:0]    dest_reg_idx;
        logic          valid;
    } IS_PACKET;

endpackage

// File: rtl/is_issue_queue_if.sv
// Enqueue/issue bundle between decode, the issue queue (slave) and EX.
interface is_issue_queue_if #(
    parameter int DEPTH = 8
);
    import sys_defs::*;

    localparam int CW = $clog2(DEPTH) + 1;

    // Both handshakes are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds its payload until then.
    logic            enq_valid;
    IS_PACKET        enq_packet;
    logic            enq_ready;
    logic            squash;
    IS_PACKET        is_packet_out;
    logic            is_valid;
    logic            ex_ready;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    modport master (
        output enq_valid, enq_packet, squash, ex_ready,
        input  enq_ready, is_packet_out, is_valid, count, full, empty
    );

    modport slave (
        input  enq_valid, enq_packet, squash, ex_ready,
        output enq_ready, is_packet_out, is_valid, count, full, empty
    );

endinterface

// File: rtl/is_mult_tracker.sv
// Tracks how long the EX multiplier stays occupied after a MULT issues.
module is_mult_tracker #(
    parameter int MULT_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic issue_mult,
    output logic busy
);
    localparam int MW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    logic [MW-1:0] mult_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_cnt <= '0;
        end else if (issue_mult) begin
            mult_cnt <= MW'(MULT_LAT - 1);
        end else if (mult_cnt != '0) begin
            mult_cnt <= mult_cnt - MW'(1);
        end
    end

    assign busy = (mult_cnt != '0);

endmodule

// File: rtl/is_issue_queue.sv
// In-order issue queue feeding EX; a MULT head stalls until the multiplier frees.
// Optional same-cycle bypass of an empty queue: define IS_QUEUE_BYPASS_EN.
module is_issue_queue
    import sys_defs::*;
#(
    parameter int DEPTH    = 8,
    parameter int MULT_LAT = 4
) (
    input  logic              clock,
    input  logic              reset,
    is_issue_queue_if.slave   q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    IS_PACKET        mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic     empty;
    logic     full;
    logic     enq_ready;
    logic     offer;
    logic     is_valid;
    logic     issue;
    logic     issue_mult;
    logic     do_enq;
    logic     do_deq;
    logic     mult_busy;
    IS_PACKET out_pkt;
`ifdef IS_QUEUE_BYPASS_EN
    logic     bypass;
`endif

    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        out_pkt   = empty ? '0 : mem[head];
        offer     = !empty;
`ifdef IS_QUEUE_BYPASS_EN
        bypass    = empty && q.enq_valid && !q.squash;
        if (bypass) begin
            out_pkt = q.enq_packet;
            offer   = 1'b1;
        end
`endif
        is_valid   = offer && !q.squash && !(out_pkt.channel == MULT && mult_busy);
        issue      = is_valid && q.ex_ready;
        issue_mult = issue && (out_pkt.channel == MULT);
        // A full queue refuses new work even if the head leaves this cycle.
        enq_ready  = !full && !q.squash;
        do_enq     = q.enq_valid && enq_ready;
        do_deq     = issue && !empty;
`ifdef IS_QUEUE_BYPASS_EN
        // A bypassed packet that issues directly never occupies an entry.
        if (bypass && issue) begin
            do_enq = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) tail <= tail + PW'(1);
            if (do_deq) head <= head + PW'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entries carry no reset; count alone decides which are live.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem[tail] <= q.enq_packet;
        end
    end

    is_mult_tracker #(
        .MULT_LAT (MULT_LAT)
    ) u_mult_tracker (
        .clock      (clock),
        .reset      (reset),
        .issue_mult (issue_mult),
        .busy       (mult_busy)
    );

    assign q.enq_ready     = enq_ready;
    assign q.is_packet_out = out_pkt;
    assign q.is_valid      = is_valid;
    assign q.count         = count;
    assign q.full          = full;
    assign q.empty         = empty;

endmodule

// File: tb/tb_is_issue_queue.sv
// Directed self-checking bench for is_issue_queue (DEPTH=8, MULT_LAT=4).
module tb_is_issue_queue;
    import sys_defs::*;

    localparam int DEPTH    = 8;
    localparam int MULT_LAT = 4;

    logic clock = 1'b0;
    logic reset;
    int   n_pass   = 0;
    int   n_checks = 0;
    logic [31:0] exp_q[$];

    is_issue_queue_if #(.DEPTH(DEPTH)) qif();

    is_issue_queue #(
        .DEPTH    (DEPTH),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .q     (qif.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000ns, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    function automatic IS_PACKET mk(input logic [31:0] pc, input channel_t ch);
        IS_PACKET p;
        p         = '0;
        p.PC      = pc;
        p.channel = ch;
        p.valid   = 1'b1;
        return p;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic enq_one(input logic [31:0] pc, input channel_t ch);
        qif.enq_valid  = 1'b1;
        qif.enq_packet = mk(pc, ch);
        step;
        qif.enq_valid  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #2;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL rst_count: got %0d want 0", qif.count); else n_pass++;
        n_checks++; if (qif.empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", qif.empty); else n_pass++;
        n_checks++; if (qif.full !== 1'b0) $display("FAIL rst_full: got %b want 0", qif.full); else n_pass++;
        n_checks++; if (qif.enq_ready !== 1'b1) $display("FAIL rst_enq_ready: got %b want 1", qif.enq_ready); else n_pass++;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL rst_is_valid: got %b want 0", qif.is_valid); else n_pass++;
        n_checks++; if (qif.is_packet_out !== '0) $display("FAIL rst_packet: got %h want 0", qif.is_packet_out); else n_pass++;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic test_fill;
        qif.ex_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(4 * i));
            enq_one(32'(4 * i), ALU);
            if (i == 0) begin
                #1;
                n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL fill_first_valid: got %b want 1", qif.is_valid); else n_pass++;
            end
        end
        #1;
        n_checks++; if (qif.full !== 1'b1) $display("FAIL fill_full: got %b want 1", qif.full); else n_pass++;
        n_checks++; if (qif.count !== 4'd8) $display("FAIL fill_count: got %0d want 8", qif.count); else n_pass++;
        n_checks++; if (qif.enq_ready !== 1'b0) $display("FAIL fill_enq_ready: got %b want 0", qif.enq_ready); else n_pass++;
        n_checks++; if (qif.is_packet_out.PC !== 32'd0) $display("FAIL fill_head_pc: got %0d want 0", qif.is_packet_out.PC); else n_pass++;
        enq_one(32'd100, ALU);
        #1;
        n_checks++; if (qif.count !== 4'd8) $display("FAIL fill_ninth_dropped: count %0d want 8", qif.count); else n_pass++;
    endtask

    task automatic test_drain;
        logic [31:0] exp_pc;
        // First drain cycle also offers a packet: full queue must refuse it.
        qif.ex_ready   = 1'b1;
        qif.enq_valid  = 1'b1;
        qif.enq_packet = mk(32'd200, ALU);
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_pc = exp_q.pop_front();
            n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL drain_valid_%0d: got %b want 1", i, qif.is_valid); else n_pass++;
            n_checks++; if (qif.is_packet_out.PC !== exp_pc) $display("FAIL drain_pc_%0d: got %0d want %0d", i, qif.is_packet_out.PC, exp_pc); else n_pass++;
            step;
            if (i == 0) begin
                qif.enq_valid = 1'b0;
                n_checks++; if (qif.count !== 4'd7) $display("FAIL drain_full_enq_rejected: count %0d want 7", qif.count); else n_pass++;
            end
        end
        qif.ex_ready = 1'b0;
        #1;
        n_checks++; if (qif.empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", qif.empty); else n_pass++;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL drain_is_valid: got %b want 0", qif.is_valid); else n_pass++;
        n_checks++; if (qif.is_packet_out !== '0) $display("FAIL drain_packet_zero: got %h want 0", qif.is_packet_out); else n_pass++;
    endtask

    task automatic test_simul;
        qif.ex_ready = 1'b0;
        enq_one(32'h10, ALU);
        enq_one(32'h14, BR);
        qif.ex_ready = 1'b1;
        enq_one(32'h18, ALU);
        qif.ex_ready = 1'b0;
        #1;
        n_checks++; if (qif.count !== 4'd2) $display("FAIL simul_count: got %0d want 2", qif.count); else n_pass++;
        n_checks++; if (qif.is_packet_out.PC !== 32'h14) $display("FAIL simul_head: got %h want 14", qif.is_packet_out.PC); else n_pass++;
        qif.ex_ready = 1'b1;
        step;
        n_checks++; if (qif.is_packet_out.PC !== 32'h18) $display("FAIL simul_tail_pc: got %h want 18", qif.is_packet_out.PC); else n_pass++;
        step;
        qif.ex_ready = 1'b0;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL simul_drained: count %0d want 0", qif.count); else n_pass++;
    endtask

    task automatic test_mult;
        int t1 = -1;
        int t2 = -1;
        int t3 = -1;
        qif.ex_ready = 1'b0;
        enq_one(32'h40, MULT);
        enq_one(32'h44, MULT);
        enq_one(32'h48, ALU);
        qif.ex_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (qif.is_valid === 1'b1) begin
                if (qif.is_packet_out.PC == 32'h40 && t1 < 0) t1 = cyc;
                if (qif.is_packet_out.PC == 32'h44 && t2 < 0) t2 = cyc;
                if (qif.is_packet_out.PC == 32'h48 && t3 < 0) t3 = cyc;
            end
            step;
        end
        qif.ex_ready = 1'b0;
        n_checks++; if (t1 !== 0) $display("FAIL mult_first_issue: cycle %0d want 0", t1); else n_pass++;
        n_checks++; if (t2 !== 4) $display("FAIL mult_second_issue: cycle %0d want 4", t2); else n_pass++;
        n_checks++; if (t3 !== 5) $display("FAIL mult_alu_issue: cycle %0d want 5", t3); else n_pass++;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL mult_drained: count %0d want 0", qif.count); else n_pass++;
    endtask

    task automatic test_squash;
        qif.ex_ready = 1'b0;
        enq_one(32'h80, ALU);
        enq_one(32'h84, ALU);
        enq_one(32'h88, ALU);
        qif.squash     = 1'b1;
        qif.enq_valid  = 1'b1;
        qif.enq_packet = mk(32'h99, ALU);
        qif.ex_ready   = 1'b1;
        #1;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL squash_valid_low: got %b want 0", qif.is_valid); else n_pass++;
        n_checks++; if (qif.enq_ready !== 1'b0) $display("FAIL squash_enq_ready: got %b want 0", qif.enq_ready); else n_pass++;
        step;
        qif.squash    = 1'b0;
        qif.enq_valid = 1'b0;
        qif.ex_ready  = 1'b0;
        #1;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL squash_count: got %0d want 0", qif.count); else n_pass++;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL squash_after_valid: got %b want 0", qif.is_valid); else n_pass++;
        enq_one(32'hA0, ALU);
        #1;
        n_checks++; if (qif.count !== 4'd1) $display("FAIL squash_reenq_count: got %0d want 1", qif.count); else n_pass++;
        n_checks++; if (qif.is_packet_out.PC !== 32'hA0) $display("FAIL squash_reenq_head: got %h want a0", qif.is_packet_out.PC); else n_pass++;
        qif.ex_ready = 1'b1;
        step;
        qif.ex_ready = 1'b0;
    endtask

    task automatic test_squash_mult;
        qif.ex_ready = 1'b0;
        enq_one(32'hC0, MULT);
        qif.ex_ready = 1'b1;
        step;
        qif.ex_ready = 1'b0;
        qif.squash   = 1'b1;
        step;
        qif.squash   = 1'b0;
        enq_one(32'hC4, MULT);
        #1;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL squash_keeps_mult_busy: is_valid %b want 0", qif.is_valid); else n_pass++;
        step;
        n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL squash_mult_released: is_valid %b want 1", qif.is_valid); else n_pass++;
        qif.ex_ready = 1'b1;
        step;
        qif.ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) step;
    endtask

    task automatic test_reset_mid;
        qif.ex_ready = 1'b0;
        enq_one(32'h100, MULT);
        for (int i = 1; i <= 5; i++) enq_one(32'h100 + 32'(4 * i), ALU);
        qif.ex_ready = 1'b1;
        step;
        qif.ex_ready = 1'b0;
        step;
        step;
        n_checks++; if (qif.count !== 4'd5) $display("FAIL rmid_count_before: got %0d want 5", qif.count); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL rmid_async_count: got %0d want 0", qif.count); else n_pass++;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL rmid_async_valid: got %b want 0", qif.is_valid); else n_pass++;
        n_checks++; if (qif.is_packet_out !== '0) $display("FAIL rmid_async_packet: got %h want 0", qif.is_packet_out); else n_pass++;
        step;
        reset = 1'b0;
        enq_one(32'h200, MULT);
        qif.ex_ready = 1'b1;
        #1;
        n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL rmid_new_mult_valid: got %b want 1", qif.is_valid); else n_pass++;
        n_checks++; if (qif.is_packet_out.PC !== 32'h200) $display("FAIL rmid_new_mult_pc: got %h want 200", qif.is_packet_out.PC); else n_pass++;
        step;
        qif.ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) step;
        // Reset right after a MULT issue, while occupancy is at its maximum.
        enq_one(32'h210, MULT);
        qif.ex_ready = 1'b1;
        step;
        qif.ex_ready = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        enq_one(32'h214, MULT);
        #1;
        n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL rmid_occupancy_cleared: is_valid %b want 1", qif.is_valid); else n_pass++;
        qif.ex_ready = 1'b1;
        step;
        qif.ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) step;
    endtask

`ifdef IS_QUEUE_BYPASS_EN
    task automatic test_bypass;
        qif.enq_valid  = 1'b1;
        qif.enq_packet = mk(32'd15, BR);
        qif.ex_ready   = 1'b1;
        #1;
        n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL bypass_valid: got %b want 1", qif.is_valid); else n_pass++;
        n_checks++; if (qif.is_packet_out.PC !== 32'd15) $display("FAIL bypass_pc: got %0d want 15", qif.is_packet_out.PC); else n_pass++;
        step;
        qif.enq_valid = 1'b0;
        qif.ex_ready  = 1'b0;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL bypass_count: got %0d want 0", qif.count); else n_pass++;
    endtask
`else
    task automatic test_latency;
        qif.enq_valid  = 1'b1;
        qif.enq_packet = mk(32'h300, ALU);
        qif.ex_ready   = 1'b1;
        #1;
        n_checks++; if (qif.is_valid !== 1'b0) $display("FAIL latency_no_bypass: is_valid %b want 0", qif.is_valid); else n_pass++;
        step;
        qif.enq_valid = 1'b0;
        n_checks++; if (qif.is_valid !== 1'b1) $display("FAIL latency_next_valid: got %b want 1", qif.is_valid); else n_pass++;
        n_checks++; if (qif.is_packet_out.PC !== 32'h300) $display("FAIL latency_pc: got %h want 300", qif.is_packet_out.PC); else n_pass++;
        step;
        qif.ex_ready = 1'b0;
        n_checks++; if (qif.count !== 4'd0) $display("FAIL latency_drained: count %0d want 0", qif.count); else n_pass++;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        reset          = 1'b1;
        qif.enq_valid  = 1'b0;
        qif.enq_packet = '0;
        qif.squash     = 1'b0;
        qif.ex_ready   = 1'b0;
        test_reset;
        test_fill;
        test_drain;
        test_simul;
        test_mult;
        test_squash;
        test_squash_mult;
        test_reset_mid;
`ifdef IS_QUEUE_BYPASS_EN
        test_bypass;
`else
        test_latency;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
